burst_bank_ram: RTL and testbench

BURST_BANK_RAM -- requirements
Module: burst_bank_ram

---
 rtl/burst_bank_ram_pkg.sv | 17 +
 rtl/burst_bank_ram_ram_bank.sv | 49 ++++
 rtl/burst_bank_ram.sv | 149 ++++++++++++++
 tb/tb_burst_bank_ram.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_bank_ram_pkg.sv
// rtl/burst_bank_ram_pkg.sv - shared state encoding and read-during-write constants
package burst_bank_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_bank_ram_ram_bank.sv
// rtl/burst_bank_ram_ram_bank.sv - single RAM bank, one write and one pipelined read port
module ram_bank
    import burst_bank_ram_pkg::*;
#(
    parameter int RAM_DEEP = 64,
    parameter int DWIDTH   = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_READ_FIRST,
    localparam int AWIDTH  = $clog2(RAM_DEEP)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [RAM_DEEP];
    logic [DWIDTH-1:0] r_rd0;

    // Contents are deliberately never reset so a mid-burst reset keeps stored data.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            if (RDW_MODE == RDW_WRITE_FIRST && we && (waddr == raddr)) begin
                r_rd0 <= wdata;
            end else begin
                r_rd0 <= r_mem[raddr];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DWIDTH-1:0] r_rd1;
            always_ff @(posedge clk) begin
                r_rd1 <= r_rd0;
            end
            assign rdata = r_rd1;
        end else begin : g_lat1
            assign rdata = r_rd0;
        end
    endgenerate

endmodule

// File: rtl/burst_bank_ram.sv
// rtl/burst_bank_ram.sv - multi-bank RAM with credit-limited burst reader and output FIFO
module burst_bank_ram
    import burst_bank_ram_pkg::*;
#(
    parameter int RAM_DEEP = 64,
    parameter int DWIDTH   = 16,
    parameter int NUM_CH   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_READ_FIRST,
    localparam int AWIDTH  = $clog2(RAM_DEEP),
    localparam int CWIDTH  = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     we,
    input  logic [CWIDTH-1:0]        wch,
    input  logic [AWIDTH-1:0]        waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        base_addr,
    input  logic [AWIDTH:0]          len,
    output logic [NUM_CH*DWIDTH-1:0] dout,
    output logic                     dvalid,
    input  logic                     dready,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH  = RD_LAT + 1;
    localparam int PWIDTH = clog2_min1(DEPTH);
    localparam int OWIDTH = $clog2(DEPTH + 1);
    localparam int BWIDTH = NUM_CH * DWIDTH;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AWIDTH-1:0]  r_addr;
    logic [AWIDTH:0]    r_remain;
    logic [RD_LAT-1:0]  r_vpipe;
    logic [OWIDTH-1:0]  r_occ;
    logic [OWIDTH-1:0]  r_infl;
    logic [PWIDTH-1:0]  r_wptr;
    logic [PWIDTH-1:0]  r_rptr;
    logic [BWIDTH-1:0]  r_fifo [DEPTH];
    logic               r_done;

    logic [BWIDTH-1:0]  w_rdata;
    logic               w_dvalid;
    logic               w_push;
    logic               w_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_busy;
    logic               w_last_pop;
    logic               w_zero_start;

    assign w_dvalid = (r_occ != '0);
    assign w_pop    = w_dvalid & dready;
    assign w_push   = r_vpipe[RD_LAT-1];
    // A beat leaving this cycle frees its slot, which keeps one issue per cycle sustainable.
    assign w_credit = ((int'(r_occ) + int'(r_infl)) < DEPTH) || w_pop;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && !r_done && (len != '0)) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue && (r_remain == (AWIDTH+1)'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue      = (r_state == ST_RUN) && w_credit;
        w_busy       = (r_state != ST_IDLE) || r_done;
        w_last_pop   = (r_state == ST_DRAIN) && w_pop && (r_occ == OWIDTH'(1)) && (r_infl == '0);
        w_zero_start = (r_state == ST_IDLE) && !r_done && start && (len == '0);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_vpipe  <= '0;
            r_occ    <= '0;
            r_infl   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done  <= w_zero_start || w_last_pop;
            r_vpipe <= (r_vpipe << 1) | RD_LAT'(w_issue);
            r_infl  <= r_infl + OWIDTH'(w_issue) - OWIDTH'(w_push);
            r_occ   <= r_occ + OWIDTH'(w_push) - OWIDTH'(w_pop);
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
                r_addr   <= base_addr;
                r_remain <= len;
            end else if (w_issue) begin
                r_addr   <= (r_addr == AWIDTH'(RAM_DEEP - 1)) ? '0 : r_addr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
            if (w_push) begin
                r_wptr <= (r_wptr == PWIDTH'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PWIDTH'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_rdata;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_bank
            ram_bank #(
                .RAM_DEEP (RAM_DEEP),
                .DWIDTH   (DWIDTH),
                .RD_LAT   (RD_LAT),
                .RDW_MODE (RDW_MODE)
            ) u_bank (
                .clk   (clk),
                .we    (we && (wch == CWIDTH'(c))),
                .waddr (waddr),
                .wdata (wdata),
                .re    (w_issue),
                .raddr (r_addr),
                .rdata (w_rdata[c*DWIDTH +: DWIDTH])
            );
        end
    endgenerate

    assign dout   = w_dvalid ? r_fifo[r_rptr] : '0;
    assign dvalid = w_dvalid;
    assign busy   = w_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_burst_bank_ram.sv
// tb/tb_burst_bank_ram.sv - directed bench for burst_bank_ram in both read-during-write modes
module tb_burst_bank_ram;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  wch = '0;
    logic [5:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  len = '0;
    logic        dready = 1'b0;

    logic [63:0] dout0, dout1;
    logic        dvalid0, dvalid1, busy0, busy1, done0, done1;

    int n_vec = 0;
    int n_miss = 0;

    logic [63:0] beats0[$];
    logic [63:0] beats1[$];
    int t_first, t_last, t_done, n_done, stall_err;

    always #5 clk = ~clk;

    burst_bank_ram #(.RAM_DEEP(64), .DWIDTH(16), .NUM_CH(4), .RD_LAT(1), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .nreset(nreset), .we(we), .wch(wch), .waddr(waddr), .wdata(wdata),
        .start(start), .base_addr(base_addr), .len(len), .dout(dout0), .dvalid(dvalid0),
        .dready(dready), .busy(busy0), .done(done0)
    );

    burst_bank_ram #(.RAM_DEEP(64), .DWIDTH(16), .NUM_CH(4), .RD_LAT(1), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .nreset(nreset), .we(we), .wch(wch), .waddr(waddr), .wdata(wdata),
        .start(start), .base_addr(base_addr), .len(len), .dout(dout1), .dvalid(dvalid1),
        .dready(dready), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int a);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            v[c*16 +: 16] = 16'((c << 8) | (a % 64));
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // t counts cycles after the edge that samples start; a read for base+t issues in cycle t.
    task automatic run_burst(input int b, input int l, input bit stall, input bit hold_start,
                             input bit inject, input int rst_at);
        logic        prev_stall;
        logic [63:0] prev_dout;
        beats0.delete();
        beats1.delete();
        t_first = -1; t_last = -1; t_done = -1; n_done = 0; stall_err = 0;
        base_addr = 6'(b);
        len = 7'(l);
        start = 1'b1;
        tick();
        if (hold_start) begin
            base_addr = 6'd40;
            len = 7'd5;
        end else begin
            start = 1'b0;
        end
        prev_stall = 1'b0;
        prev_dout = '0;
        for (int t = 0; t < 400; t++) begin
            dready = stall ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            if (inject) begin
                we = (t == 5);
                wch = 2'd1;
                waddr = 6'd5;
                wdata = 16'hBEEF;
            end
            if (rst_at >= 0 && beats0.size() == rst_at) begin
                chk("pre_rst_dvalid", 64'(dvalid0), 64'd1);
                nreset = 1'b0;
                #1;
                chk("rst_dvalid", 64'(dvalid0), 64'd0);
                chk("rst_busy", 64'(busy0), 64'd0);
                chk("rst_done", 64'(done0), 64'd0);
                chk("rst_dout", dout0, 64'd0);
                start = 1'b0;
                dready = 1'b0;
                tick();
                nreset = 1'b1;
                tick();
                chk("rst_busy_after", 64'(busy0), 64'd0);
                return;
            end
            if (prev_stall && (!dvalid0 || dout0 !== prev_dout)) stall_err++;
            if (dvalid0 && dready) begin
                if (t_first < 0) t_first = t;
                t_last = t;
                beats0.push_back(dout0);
                beats1.push_back(dout1);
            end
            if (done0) begin
                n_done++;
                if (t_done < 0) t_done = t;
                start = 1'b0;
            end
            prev_stall = dvalid0 && !dready;
            prev_dout = dout0;
            if (t_done >= 0 && t == t_done + 1) begin
                chk("busy_after_done", 64'(busy0), 64'd0);
                break;
            end
            tick();
        end
        if (t_done < 0) chk("burst_timeout", 64'd0, 64'd1);
        dready = 1'b0;
        we = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        logic seen_dv, seen_busy;

        #1;
        tick();
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_dvalid", 64'(dvalid0), 64'd0);
        chk("reset_dout", dout0, 64'd0);
        nreset = 1'b1;
        tick();

        for (int a = 0; a < 64; a++) begin
            for (int c = 0; c < 4; c++) begin
                we = 1'b1;
                wch = 2'(c);
                waddr = 6'(a);
                wdata = 16'((c << 8) | a);
                tick();
            end
        end
        we = 1'b0;
        tick();

        run_burst(0, 64, 1'b0, 1'b0, 1'b0, -1);
        chk("b64_count", 64'(beats0.size()), 64'd64);
        chk("b64_first_lat", 64'(t_first), 64'd2);
        chk("b64_throughput", 64'(t_last - t_first), 64'd63);
        chk("b64_done_lat", 64'(t_done), 64'(t_last + 1));
        chk("b64_done_width", 64'(n_done), 64'd1);
        for (int k = 0; k < 64; k++) begin
            v = beats0[k];
            chk($sformatf("b64_beat%0d", k), v, exp_beat(k));
        end
        tick();

        run_burst(62, 4, 1'b0, 1'b0, 1'b0, -1);
        chk("wrap_count", 64'(beats0.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            v = beats0[k];
            chk($sformatf("wrap_beat%0d", k), v, exp_beat(62 + k));
        end
        tick();

        run_burst(10, 16, 1'b1, 1'b1, 1'b0, -1);
        chk("stall_count", 64'(beats0.size()), 64'd16);
        chk("stall_hold", 64'(stall_err), 64'd0);
        chk("stall_done_width", 64'(n_done), 64'd1);
        for (int k = 0; k < 16; k++) begin
            v = beats0[k];
            chk($sformatf("stall_beat%0d", k), v, exp_beat(10 + k));
        end
        tick();

        base_addr = 6'd0;
        len = 7'd0;
        start = 1'b1;
        tick();
        chk("len0_done", 64'(done0), 64'd1);
        chk("len0_busy", 64'(busy0), 64'd1);
        seen_dv = dvalid0;
        len = 7'd4;
        dready = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done_fall", 64'(done0), 64'd0);
        seen_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen_dv |= dvalid0;
            seen_busy |= busy0;
            tick();
        end
        chk("len0_no_beat", 64'(seen_dv), 64'd0);
        chk("busy_start_ignored", 64'(seen_busy), 64'd0);
        dready = 1'b0;
        tick();

        run_burst(0, 32, 1'b0, 1'b0, 1'b0, 7);
        tick();
        run_burst(0, 32, 1'b0, 1'b0, 1'b0, -1);
        chk("reburst_count", 64'(beats0.size()), 64'd32);
        for (int k = 0; k < 32; k++) begin
            v = beats0[k];
            chk($sformatf("reburst_beat%0d", k), v, exp_beat(k));
        end
        tick();

        run_burst(0, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("rdw_count", 64'(beats0.size()), 64'd8);
        v = beats0[5];
        chk("rdw_mode0_lane1", 64'(v[31:16]), 64'h0105);
        chk("rdw_mode0_beat5", v, exp_beat(5));
        v = beats1[5];
        chk("rdw_mode1_lane1", 64'(v[31:16]), 64'hBEEF);
        chk("rdw_mode1_lane0", 64'(v[15:0]), 64'h0005);
        v = beats1[6];
        chk("rdw_mode1_beat6", v, exp_beat(6));
        tick();

        run_burst(5, 1, 1'b0, 1'b0, 1'b0, -1);
        v = beats0[0];
        chk("rdw_written_mode0", 64'(v[31:16]), 64'hBEEF);
        v = beats1[0];
        chk("rdw_written_mode1", 64'(v[31:16]), 64'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
